// File: rtl/sampler_sequencer.sv
// Capture controller for the logic-analyser sampler: register programming, capture sequencing
// and a first-word-fall-through output FIFO. Define SAMPLER_SEQ_MUX_EN to add input-mux writes.
module sampler_sequencer #(
  parameter int depth = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic [31:0] cfg_period,
  input  logic [31:0] cfg_edge_mask,
  input  logic [31:0] cfg_limit,
`ifdef SAMPLER_SEQ_MUX_EN
  input  logic [63:0] cfg_mux,
`endif
  output logic [4:0]  smp_waddr,
  output logic [31:0] smp_wdata,
  output logic        smp_wvalid,
  input  logic [15:0] smp_data,
  input  logic        smp_valid,
  input  logic        smp_overflow,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] word_count,
  output logic        fifo_overflow,
  output logic        cmp_overflow
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] CFG_PERIOD = 4'd1;
  localparam logic [3:0] CFG_MASK   = 4'd2;
  localparam logic [3:0] CFG_ENABLE = 4'd3;
  localparam logic [3:0] RUN        = 4'd4;
  localparam logic [3:0] STOP_EN    = 4'd5;
  localparam logic [3:0] STOP_MASK  = 4'd6;
  localparam logic [3:0] DRAIN      = 4'd7;
`ifdef SAMPLER_SEQ_MUX_EN
  localparam logic [3:0] CFG_MUX_LO = 4'd8;
  localparam logic [3:0] CFG_MUX_HI = 4'd9;
`endif

  localparam int PtrW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(depth);

  logic [3:0]      state_q, state_d;
  logic [1:0]      drainCnt_q, drainCnt_d;
  logic            wvalid_q, wvalid_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            done_q, done_d;
  logic            busy_q;
  logic [31:0]     wordCount_q, wordCount_d;
  logic            fifoOvf_q, fifoOvf_d;
  logic            cmpOvf_q, cmpOvf_d;
  logic            outValid_q;
  logic [15:0]     mem [depth];
  logic [PtrW-1:0] rdPtr_q, wrPtr_q;
  logic [CntW-1:0] count_q, count_d;

  logic busyNow, startNow, limitReached, pop, full, accept, push, dropWord, limitHit;

  assign busyNow      = (state_q != IDLE);
  assign startNow     = (state_q == IDLE) && cmd_start;
  assign limitReached = (cfg_limit != '0) && (wordCount_q >= cfg_limit);
  assign pop          = outValid_q && out_ready;
  assign full         = (count_q == FullCount);
  assign accept       = smp_valid && busyNow && !limitReached;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push         = accept && (!full || pop);
  assign dropWord     = accept && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    wordCount_d = wordCount_q;
    fifoOvf_d   = fifoOvf_q | dropWord;
    cmpOvf_d    = cmpOvf_q | (busyNow & smp_overflow);
    if (startNow) begin
      wordCount_d = '0;
      fifoOvf_d   = 1'b0;
      cmpOvf_d    = 1'b0;
    end else if (push && (wordCount_q != '1)) begin
      wordCount_d = wordCount_q + 32'd1;
    end
  end

  assign limitHit = (cfg_limit != '0) && (wordCount_d >= cfg_limit);

  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    wvalid_d   = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (cmd_start) state_d = CFG_PERIOD;
      CFG_PERIOD: begin
        if (cmd_stop) state_d = STOP_EN;
        else begin
          wvalid_d = 1'b1;
          waddr_d  = 5'h04;
          wdata_d  = cfg_period;
          state_d  = CFG_MASK;
        end
      end
      CFG_MASK: begin
        if (cmd_stop) state_d = STOP_EN;
        else begin
          wvalid_d = 1'b1;
          waddr_d  = 5'h08;
          wdata_d  = cfg_edge_mask;
`ifdef SAMPLER_SEQ_MUX_EN
          state_d  = CFG_MUX_LO;
`else
          state_d  = CFG_ENABLE;
`endif
        end
      end
`ifdef SAMPLER_SEQ_MUX_EN
      CFG_MUX_LO: begin
        if (cmd_stop) state_d = STOP_EN;
        else begin
          wvalid_d = 1'b1;
          waddr_d  = 5'h10;
          wdata_d  = cfg_mux[31:0];
          state_d  = CFG_MUX_HI;
        end
      end
      CFG_MUX_HI: begin
        if (cmd_stop) state_d = STOP_EN;
        else begin
          wvalid_d = 1'b1;
          waddr_d  = 5'h14;
          wdata_d  = cfg_mux[63:32];
          state_d  = CFG_ENABLE;
        end
      end
`endif
      CFG_ENABLE: begin
        if (cmd_stop) state_d = STOP_EN;
        else begin
          wvalid_d = 1'b1;
          waddr_d  = 5'h00;
          wdata_d  = 32'd3;
          state_d  = RUN;
        end
      end
      RUN: if (cmd_stop || limitHit || dropWord) state_d = STOP_EN;
      STOP_EN: begin
        wvalid_d = 1'b1;
        state_d  = STOP_MASK;
      end
      STOP_MASK: begin
        wvalid_d   = 1'b1;
        waddr_d    = 5'h08;
        drainCnt_d = '0;
        state_d    = DRAIN;
      end
      DRAIN: begin
        // Grace period lets the compressor flush tail words before the FIFO-empty exit.
        if (drainCnt_q != 2'd3) drainCnt_d = drainCnt_q + 2'd1;
        else if (count_d == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drainCnt_q  <= '0;
      wvalid_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      wordCount_q <= '0;
      fifoOvf_q   <= 1'b0;
      cmpOvf_q    <= 1'b0;
      outValid_q  <= 1'b0;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      drainCnt_q  <= drainCnt_d;
      wvalid_q    <= wvalid_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      busy_q      <= (state_d != IDLE);
      wordCount_q <= wordCount_d;
      fifoOvf_q   <= fifoOvf_d;
      cmpOvf_q    <= cmpOvf_d;
      outValid_q  <= (count_d != '0);
      count_q     <= count_d;
      if (push) wrPtr_q <= wrPtr_q + PtrW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q] <= smp_data;
  end

  assign smp_wvalid    = wvalid_q;
  assign smp_waddr     = waddr_q;
  assign smp_wdata     = wdata_q;
  assign out_data      = mem[rdPtr_q];
  assign out_valid     = outValid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign word_count    = wordCount_q;
  assign fifo_overflow = fifoOvf_q;
  assign cmp_overflow  = cmpOvf_q;

endmodule

// File: tb/tb_sampler_sequencer.sv
// Self-checking bench for sampler_sequencer: directed scenarios plus randomized traffic, every cycle
// compared with a queue-based transaction model. Honours SAMPLER_SEQ_MUX_EN like the design.
module tb_sampler_sequencer;
  localparam int Depth = 16;
`ifdef SAMPLER_SEQ_MUX_EN
  localparam int CfgWrites = 5;
`else
  localparam int CfgWrites = 3;
`endif

  logic        clk;
  logic        rst_n, cmd_start, cmd_stop;
  logic [31:0] cfg_period, cfg_edge_mask, cfg_limit;
`ifdef SAMPLER_SEQ_MUX_EN
  logic [63:0] cfg_mux;
`endif
  logic [4:0]  smp_waddr;
  logic [31:0] smp_wdata;
  logic        smp_wvalid;
  logic [15:0] smp_data;
  logic        smp_valid, smp_overflow;
  logic [15:0] out_data;
  logic        out_valid, out_ready;
  logic        busy, done;
  logic [31:0] word_count;
  logic        fifo_overflow, cmp_overflow;

  sampler_sequencer #(.depth(Depth)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cfg_period(cfg_period), .cfg_edge_mask(cfg_edge_mask), .cfg_limit(cfg_limit),
`ifdef SAMPLER_SEQ_MUX_EN
    .cfg_mux(cfg_mux),
`endif
    .smp_waddr(smp_waddr), .smp_wdata(smp_wdata), .smp_wvalid(smp_wvalid),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_overflow(smp_overflow),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .word_count(word_count),
    .fifo_overflow(fifo_overflow), .cmp_overflow(cmp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef enum {M_IDLE, M_CONFIG, M_RUN, M_STOPPING, M_DRAIN} phase_t;

  int          checks = 0;
  int          errors = 0;
  int          cycleNum = 0;
  wr_t         wrLog[$];
  logic [15:0] popLog[$];
  logic [15:0] offered[$];

  // Reference model: capture phase, pending register writes as symbolic codes, FIFO as a queue.
  phase_t      mPhase;
  int          mPending[$];
  logic [15:0] mFifo[$];
  logic [31:0] mCount;
  logic        mFovf, mCovf, mDone, mWvalid;
  logic [4:0]  mWaddr;
  logic [31:0] mWdata;
  int          mDrainCycles;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cycleNum);
    end
  endtask

  task automatic modelReset();
    mPhase = M_IDLE;
    mPending.delete();
    mFifo.delete();
    mCount = 0;
    mFovf = 0;
    mCovf = 0;
    mDrainCycles = 0;
  endtask

  task automatic emit(input int code);
    mWvalid = 1'b1;
    case (code)
      0: begin mWaddr = 5'h04; mWdata = cfg_period; end
      1: begin mWaddr = 5'h08; mWdata = cfg_edge_mask; end
`ifdef SAMPLER_SEQ_MUX_EN
      2: begin mWaddr = 5'h10; mWdata = cfg_mux[31:0]; end
      3: begin mWaddr = 5'h14; mWdata = cfg_mux[63:32]; end
`endif
      4: begin mWaddr = 5'h00; mWdata = 32'd3; end
      5: begin mWaddr = 5'h00; mWdata = 32'd0; end
      default: begin mWaddr = 5'h08; mWdata = 32'd0; end
    endcase
  endtask

  task automatic loadStop();
    mPending.delete();
    mPending.push_back(5);
    mPending.push_back(6);
    mPhase = M_STOPPING;
  endtask

  task automatic modelEdge();
    bit active, limitReached, pop, offer, push, drop;
    mWvalid = 0;
    mWaddr = 0;
    mWdata = 0;
    mDone = 0;
    if (!rst_n) begin
      modelReset();
      return;
    end
    active = (mPhase != M_IDLE);
    limitReached = (cfg_limit != 0) && (mCount >= cfg_limit);
    pop = (mFifo.size() > 0) && out_ready;
    offer = smp_valid && active && !limitReached;
    push = offer && ((mFifo.size() < Depth) || pop);
    drop = offer && !push;
    if (pop) void'(mFifo.pop_front());
    if (push) begin
      mFifo.push_back(smp_data);
      if (mCount != 32'hFFFF_FFFF) mCount++;
    end
    if (drop) mFovf = 1;
    if (active && smp_overflow) mCovf = 1;
    case (mPhase)
      M_IDLE: if (cmd_start) begin
        mCount = 0;
        mFovf = 0;
        mCovf = 0;
        mPending.delete();
        mPending.push_back(0);
        mPending.push_back(1);
`ifdef SAMPLER_SEQ_MUX_EN
        mPending.push_back(2);
        mPending.push_back(3);
`endif
        mPending.push_back(4);
        mPhase = M_CONFIG;
      end
      M_CONFIG: begin
        if (cmd_stop) loadStop();
        else begin
          emit(mPending.pop_front());
          if (mPending.size() == 0) mPhase = M_RUN;
        end
      end
      M_RUN: if (cmd_stop || drop || ((cfg_limit != 0) && (mCount >= cfg_limit))) loadStop();
      M_STOPPING: begin
        emit(mPending.pop_front());
        if (mPending.size() == 0) begin
          mPhase = M_DRAIN;
          mDrainCycles = 0;
        end
      end
      default: begin
        mDrainCycles++;
        if ((mDrainCycles >= 4) && (mFifo.size() == 0)) begin
          mDone = 1;
          mPhase = M_IDLE;
        end
      end
    endcase
  endtask

  // One clock: log a pending pop, advance the model on the edge, then compare all outputs.
  task automatic applyStimulus();
    if (rst_n && out_valid && out_ready) popLog.push_back(out_data);
    @(posedge clk);
    modelEdge();
    cycleNum++;
    #1;
    if (smp_wvalid) wrLog.push_back('{smp_waddr, smp_wdata, cycleNum});
    checkOutput("busy", busy, mPhase != M_IDLE);
    checkOutput("done", done, mDone);
    checkOutput("out_valid", out_valid, mFifo.size() > 0);
    if (mFifo.size() > 0) checkOutput("out_data", out_data, mFifo[0]);
    checkOutput("word_count", word_count, mCount);
    checkOutput("fifo_overflow", fifo_overflow, mFovf);
    checkOutput("cmp_overflow", cmp_overflow, mCovf);
    checkOutput("smp_wvalid", smp_wvalid, mWvalid);
    checkOutput("smp_waddr", smp_waddr, mWaddr);
    checkOutput("smp_wdata", smp_wdata, mWdata);
  endtask

  task automatic waitDone(input int budget, input string tag, output int doneCyc);
    bit seen;
    seen = 0;
    doneCyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      applyStimulus();
      if (done) begin
        seen = 1;
        doneCyc = cycleNum;
      end
    end
    checkOutput({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic startCapture();
    cmd_start = 1;
    applyStimulus();
    cmd_start = 0;
  endtask

  task automatic offerWords(input int n);
    for (int i = 0; i < n; i++) begin
      smp_data = 16'($urandom);
      offered.push_back(smp_data);
      smp_valid = 1;
      applyStimulus();
    end
    smp_valid = 0;
  endtask

  initial begin
    int startEdge, doneCyc, readyPct;
    bit sawEnable;
    wr_t expW[$];

    rst_n = 0; cmd_start = 0; cmd_stop = 0;
    cfg_period = 0; cfg_edge_mask = 0; cfg_limit = 0;
`ifdef SAMPLER_SEQ_MUX_EN
    cfg_mux = 64'h0123_4567_89AB_CDEF;
`endif
    smp_data = 0; smp_valid = 0; smp_overflow = 0; out_ready = 0;
    modelReset();

    for (int i = 0; i < 4; i++) begin
      smp_valid = 1'($urandom);
      smp_data = 16'($urandom);
      applyStimulus();
    end
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_wvalid", smp_wvalid, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_word_count", word_count, 0);
    rst_n = 1;
    smp_valid = 1;
    repeat (3) applyStimulus();
    smp_valid = 0;
    checkOutput("idle_discard_count", word_count, 0);
    checkOutput("idle_discard_valid", out_valid, 0);

    // Start, configure, capture with a limit of 5 out of 8 offered words.
    $display("[TB] scenario: start and word limit");
    wrLog.delete(); popLog.delete(); offered.delete();
    cfg_period = 9; cfg_edge_mask = 32'h0001_0001; cfg_limit = 5; out_ready = 1;
    startCapture();
    startEdge = cycleNum;
    checkOutput("s1_busy_rise", busy, 1);
    repeat (CfgWrites) applyStimulus();
    expW.delete();
    expW.push_back('{5'h04, 32'd9, 0});
    expW.push_back('{5'h08, 32'h0001_0001, 0});
`ifdef SAMPLER_SEQ_MUX_EN
    expW.push_back('{5'h10, 32'h89AB_CDEF, 0});
    expW.push_back('{5'h14, 32'h0123_4567, 0});
`endif
    expW.push_back('{5'h00, 32'd3, 0});
    checkOutput("s1_cfg_writes", wrLog.size(), CfgWrites);
    for (int k = 0; k < CfgWrites && k < wrLog.size(); k++) begin
      checkOutput($sformatf("s1_wr%0d", k), {wrLog[k].addr, wrLog[k].data}, {expW[k].addr, expW[k].data});
      checkOutput($sformatf("s1_wr%0d_cycle", k), wrLog[k].cyc, startEdge + k + 1);
    end
    offerWords(8);
    waitDone(60, "s1", doneCyc);
    checkOutput("s1_pop_count", popLog.size(), 5);
    for (int k = 0; k < 5 && k < popLog.size(); k++)
      checkOutput($sformatf("s1_pop%0d", k), popLog[k], offered[k]);
    checkOutput("s1_word_count", word_count, 5);
    checkOutput("s1_total_writes", wrLog.size(), CfgWrites + 2);
    if (wrLog.size() == CfgWrites + 2) begin
      checkOutput("s1_stop_en", {wrLog[CfgWrites].addr, wrLog[CfgWrites].data}, {5'h00, 32'd0});
      checkOutput("s1_stop_mask", {wrLog[CfgWrites+1].addr, wrLog[CfgWrites+1].data}, {5'h08, 32'd0});
      checkOutput("s1_drain_len", doneCyc - wrLog[CfgWrites+1].cyc, 4);
    end
    checkOutput("s1_busy_fall", busy, 0);

    // Overflow: consumer stalled, 17 words into a 16-deep FIFO.
    $display("[TB] scenario: fifo overflow");
    wrLog.delete(); popLog.delete(); offered.delete();
    cfg_limit = 0; out_ready = 0;
    startCapture();
    repeat (CfgWrites) applyStimulus();
    offerWords(17);
    repeat (8) applyStimulus();
    checkOutput("s2_fifo_overflow", fifo_overflow, 1);
    checkOutput("s2_stop_writes", wrLog.size(), CfgWrites + 2);
    checkOutput("s2_still_busy", busy, 1);
    out_ready = 1;
    waitDone(60, "s2", doneCyc);
    checkOutput("s2_pop_count", popLog.size(), 16);
    for (int k = 0; k < 16 && k < popLog.size(); k++)
      checkOutput($sformatf("s2_pop%0d", k), popLog[k], offered[k]);
    checkOutput("s2_word_count", word_count, 16);

    // Stop during CFG_MASK skips the remaining configuration.
    $display("[TB] scenario: stop during config");
    wrLog.delete(); popLog.delete();
    startCapture();
    applyStimulus();
    cmd_stop = 1;
    applyStimulus();
    cmd_stop = 0;
    waitDone(40, "s3", doneCyc);
    checkOutput("s3_write_count", wrLog.size(), 3);
    if (wrLog.size() >= 2)
      checkOutput("s3_next_write", {wrLog[1].addr, wrLog[1].data}, {5'h00, 32'd0});
    sawEnable = 0;
    foreach (wrLog[k]) if (wrLog[k].addr == 5'h00 && wrLog[k].data == 32'd3) sawEnable = 1;
    checkOutput("s3_no_enable", sawEnable, 0);

    // Compressor overflow is sticky, does not stop, and is cleared by the next start.
    $display("[TB] scenario: compressor overflow");
    startCapture();
    repeat (CfgWrites) applyStimulus();
    offerWords(3);
    smp_overflow = 1;
    applyStimulus();
    smp_overflow = 0;
    repeat (3) applyStimulus();
    checkOutput("s4_cmp_overflow", cmp_overflow, 1);
    checkOutput("s4_running", busy, 1);
    cmd_stop = 1;
    applyStimulus();
    cmd_stop = 0;
    waitDone(40, "s4", doneCyc);
    checkOutput("s4_cmp_sticky", cmp_overflow, 1);
    startCapture();
    checkOutput("s4_cmp_cleared", cmp_overflow, 0);
    cmd_stop = 1;
    applyStimulus();
    cmd_stop = 0;
    waitDone(40, "s4b", doneCyc);

    // Randomized traffic with commands, resets and varying consumer throughput.
    $display("[TB] scenario: random traffic");
    for (int seg = 0; seg < 5; seg++) begin
      readyPct = (seg == 4) ? 0 : $urandom_range(2, 9);
      cfg_limit = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
      cfg_period = $urandom;
      cfg_edge_mask = $urandom;
`ifdef SAMPLER_SEQ_MUX_EN
      cfg_mux = {$urandom, $urandom};
`endif
      for (int i = 0; i < 300; i++) begin
        rst_n = ($urandom_range(0, 199) != 0);
        cmd_start = ($urandom_range(0, 19) == 0);
        cmd_stop = ($urandom_range(0, 29) == 0);
        smp_valid = 1'($urandom);
        smp_data = 16'($urandom);
        smp_overflow = ($urandom_range(0, 29) == 0);
        out_ready = ($urandom_range(0, 9) < readyPct);
        applyStimulus();
      end
    end
    rst_n = 1; cmd_start = 0; smp_valid = 0; smp_overflow = 0; out_ready = 1;
    cmd_stop = 1;
    applyStimulus();
    cmd_stop = 0;
    repeat (40) applyStimulus();
    checkOutput("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sampler_sequencer.md
# sampler_sequencer

Capture controller for the logic-analyser sampler. It programs the sampler through its register write port and sequences a capture: configure, run, stop, drain. It buffers the compressed sample stream in a small FIFO with a ready/valid output toward the host transport, and stops on command, on a word limit, or on buffer overflow.

## Interface
- `depth`, 16: output FIFO depth in 16-bit words, power of two, ≥4
- `clk`  in  1  clock for all logic
- `rst_n`  in  1  reset, synchronous, active-low
- `cmd_start`  in  1  one-cycle pulse; begins a capture
- `cmd_stop`  in  1  one-cycle pulse; ends a capture
- `cfg_period`  in  32  periodic strobe period, written to sampler addr 0x04
- `cfg_edge_mask`  in  32  [15:0] rising mask, [31:16] falling mask, written to addr 0x08
- `cfg_limit`  in  32  number of words to capture; 0 = unlimited
- `smp_waddr`  out  5  sampler register address
- `smp_wdata`  out  32  sampler register data
- `smp_wvalid`  out  1  sampler register write strobe
- `smp_data`  in  16  compressed stream from sampler
- `smp_valid`  in  1  stream strobe
- `smp_overflow`  in  1  compressor overflow flag
- `out_data`  out  16  FIFO head word
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts the head word
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse on return to IDLE
- `word_count`  out  32  words pushed this capture
- `fifo_overflow`  out  1  sticky; a word was dropped because the FIFO was full
- `cmp_overflow`  out  1  sticky copy of `smp_overflow`

## Operation
- States: IDLE → CFG_PERIOD → CFG_MASK → CFG_ENABLE → RUN → STOP_EN → STOP_MASK → DRAIN → IDLE.
- `smp_*` write port and all status outputs are registered.
- Each CFG state and each STOP state issues exactly one write, then advances.
- Write sequence:
  - CFG_PERIOD: addr 0x04, data `cfg_period`
  - CFG_MASK: addr 0x08, data `cfg_edge_mask`
  - CFG_ENABLE: addr 0x00, data 3 (enable, clear counter)
  - STOP_EN: addr 0x00, data 0
  - STOP_MASK: addr 0x08, data 0
- When `smp_wvalid` is 0, `smp_waddr` and `smp_wdata` are 0.
- `cmd_start` in IDLE clears `word_count`, `fifo_overflow` and `cmp_overflow`, then enters CFG_PERIOD. `cmd_start` outside IDLE is ignored.
- `cmd_stop`:
  - in a CFG state: jumps to STOP_EN next cycle; remaining config writes are skipped.
  - in RUN: enters STOP_EN.
  - elsewhere: ignored.
  - Simultaneous with `cmd_start` in IDLE: start wins.
- Push rule: push when `smp_valid` is set in any state except IDLE, the limit is not yet reached, and the FIFO is not full.
  - If full but popping in the same cycle, the push is accepted.
  - `smp_valid` in IDLE is discarded silently.
- Limit: when `cfg_limit` ≠ 0 and `word_count` reaches `cfg_limit`, further words are discarded (not counted). RUN enters STOP_EN on the cycle the count reaches the limit.
- Overflow: `smp_valid` && full && no pop sets `fifo_overflow` and drops the word. In RUN it forces STOP_EN.
- `cmp_overflow` is set whenever `smp_overflow` is 1 while busy. It does not stop the capture.
- DRAIN: stays at least 4 cycles (grace for compressor tail words), then until the FIFO is empty. Then pulses `done` and enters IDLE.
- `word_count` is 32-bit and saturates at 0xFFFFFFFF.

## Timing
- Reset values: `smp_wvalid`=0, `smp_waddr`=0, `smp_wdata`=0, `out_valid`=0, `busy`=0, `done`=0, `word_count`=0, `fifo_overflow`=0, `cmp_overflow`=0. FIFO empty, state IDLE.
- `rst_n` low mid-capture aborts on the next edge; no stop writes are issued.
- `cmd_start` at edge N produces write 0x04 at N+1, 0x08 at N+2, 0x00 at N+3. RUN begins at N+4.
- FIFO is first-word-fall-through: a word pushed at edge N gives `out_valid`=1 with that word after edge N.
- A pop occurs when `out_valid` && `out_ready` at an edge. `out_data` is stable while `out_valid` && !`out_ready`.
- `busy` rises at the edge after `cmd_start`. It falls in the same edge that `done` pulses.

## Configuration
- `SAMPLER_SEQ_MUX_EN` defined:
  - adds input `cfg_mux` [63:0] and states CFG_MUX_LO and CFG_MUX_HI, inserted between CFG_MASK and CFG_ENABLE.
  - CFG_MUX_LO writes addr 0x10, data `cfg_mux[31:0]`; CFG_MUX_HI writes addr 0x14, data `cfg_mux[63:32]`.
  - Enable write moves to N+5; RUN begins at N+6.
- Undefined: no `cfg_mux` port and no mux writes; the sampler input mux keeps its reset mapping.

## Test plan
- `cmd_start` with period=9, mask=0x00010001 → writes (0x04,9), (0x08,0x00010001), (0x00,3) on cycles 1–3; `busy`=1.
- RUN, `cfg_limit`=5, 8 words offered, `out_ready`=1 → exactly 5 words out in order; `word_count`=5; stop writes (0x00,0), (0x08,0); `done` ≥4 cycles later.
- `depth`=16, `out_ready`=0, 17 words offered → `fifo_overflow`=1, 17th word dropped, stop sequence entered. After `out_ready`=1, 16 words drain, then `done`.
- `cmd_stop` during CFG_MASK → next write is (0x00,0); no (0x00,3) write ever issued.
- `smp_overflow` pulse during RUN → `cmp_overflow`=1 and capture continues. Next `cmd_start` clears it.
- With `SAMPLER_SEQ_MUX_EN`, `cfg_mux`=0x0123456789ABCDEF → writes (0x10,0x89ABCDEF), (0x14,0x01234567) precede (0x00,3) on cycle 5.
